// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller for the 16-bit register-file datapath.
// Fetches over a req/ack handshake, drives register-file and ALU controls, tracks pc, halt/fault and retired count.
module instr_sequencer #(
   parameter int PC_W          = 8,
   parameter int START_PC      = 0,
   parameter int FETCH_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [15:0]     imem_rdata,
   output logic [2:0]      rf_raddr1,
   output logic [2:0]      rf_raddr2,
   output logic [2:0]      rf_waddr,
   output logic            rf_we,
   output logic            alu_op,
   output logic            alu_src_imm,
   output logic [15:0]     imm_out,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            halted,
   output logic            fault,
   output logic [15:0]     instr_count
);

   localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
   localparam logic [PC_W-1:0]  START_ADDR = PC_W'(START_PC);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(FETCH_TIMEOUT - 1);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_SUBI = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_HALT = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [15:0]       r_ir;
   logic [PC_W-1:0]   r_pc;
   logic [15:0]       r_count;
   logic              r_fault;
   logic [CNT_W-1:0]  r_wait;

   logic [2:0]        w_opcode;
   logic              w_halt_op;
   logic              w_writes;
   logic              w_sub;
   logic              w_use_imm;
   logic              w_timeout;
   logic signed [15:0] w_imm_sext;

   function automatic logic signed [15:0] sext7(input logic [6:0] v);
      return {{9{v[6]}}, v};
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign w_opcode   = r_ir[15:13];
   assign w_halt_op  = (w_opcode == OP_HALT);
   assign w_writes   = (w_opcode == OP_ADD) || (w_opcode == OP_ADDI) ||
                       (w_opcode == OP_SUBI) || (w_opcode == OP_SUB);
   assign w_sub      = (w_opcode == OP_SUBI) || (w_opcode == OP_SUB);
   assign w_use_imm  = (w_opcode == OP_ADDI) || (w_opcode == OP_SUBI);
   assign w_timeout  = (r_wait == WAIT_LAST);
   assign w_imm_sext = sext7(r_ir[6:0]);

   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign fault       = r_fault;
   assign instr_count = r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and Moore outputs; register/ALU fields stay valid from their first stage through WB
   always_comb begin
      w_state_nxt = r_state;
      imem_req    = 1'b0;
      rf_raddr1   = 3'd0;
      rf_raddr2   = 3'd0;
      rf_waddr    = 3'd0;
      rf_we       = 1'b0;
      alu_op      = 1'b0;
      alu_src_imm = 1'b0;
      imm_out     = 16'd0;
      busy        = 1'b0;
      halted      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            busy     = 1'b1;
            if (imem_ack)       w_state_nxt = S_DECODE;
            else if (w_timeout) w_state_nxt = S_HALT;
         end
         S_DECODE: begin
            busy        = 1'b1;
            rf_raddr1   = r_ir[9:7];
            rf_raddr2   = r_ir[6:4];
            rf_waddr    = r_ir[12:10];
            w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            busy        = 1'b1;
            rf_raddr1   = r_ir[9:7];
            rf_raddr2   = r_ir[6:4];
            rf_waddr    = r_ir[12:10];
            alu_op      = w_sub;
            alu_src_imm = w_use_imm;
            imm_out     = w_imm_sext;
            w_state_nxt = S_WB;
         end
         S_WB: begin
            busy        = 1'b1;
            rf_raddr1   = r_ir[9:7];
            rf_raddr2   = r_ir[6:4];
            rf_waddr    = r_ir[12:10];
            alu_op      = w_sub;
            alu_src_imm = w_use_imm;
            imm_out     = w_imm_sext;
            rf_we       = w_writes;
            w_state_nxt = w_halt_op ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            if (start) w_state_nxt = S_FETCH;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Architectural state: pc, instruction register, fault flag, retired count, fetch wait counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc    <= START_ADDR;
         r_ir    <= 16'd0;
         r_count <= 16'd0;
         r_fault <= 1'b0;
         r_wait  <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  r_pc    <= START_ADDR;
                  r_count <= 16'd0;
                  r_fault <= 1'b0;
                  r_wait  <= '0;
               end
            end
            S_FETCH: begin
               if (imem_ack) begin
                  r_ir   <= imem_rdata;
                  r_wait <= '0;
               end else if (w_timeout) begin
                  r_fault <= 1'b1;
                  r_wait  <= '0;
               end else begin
                  r_wait <= r_wait + CNT_W'(1);
               end
            end
            S_WB: begin
               r_count <= sat_inc16(r_count);
               if (!w_halt_op) r_pc <= r_pc + PC_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: random and directed programs run against an instruction-level model,
// retirements checked by a decoupled scoreboard monitor.
module tb_instr_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, imem_ack;
   logic [15:0] imem_rdata;
   logic        imem_req, rf_we, alu_op, alu_src_imm, busy, halted, fault;
   logic [7:0]  imem_addr, pc;
   logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
   logic [15:0] imm_out, instr_count;

   instr_sequencer #(.PC_W(8), .START_PC(0), .FETCH_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr), .rf_we(rf_we),
      .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm_out(imm_out),
      .pc(pc), .busy(busy), .halted(halted), .fault(fault), .instr_count(instr_count)
   );

   // Second instance with a 2-bit pc, always acking with NOP
   logic        start2, req2, ack2, we2, aop2, simm2, busy2, halted2, fault2;
   logic [1:0]  addr2, pc2;
   logic [15:0] rdata2, imm2, cnt2;
   logic [2:0]  ra1_2, ra2_2, wa2;
   assign ack2   = req2;
   assign rdata2 = 16'h8000;

   instr_sequencer #(.PC_W(2), .START_PC(0), .FETCH_TIMEOUT(16)) dut2 (
      .clk(clk), .reset(reset), .start(start2),
      .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
      .rf_raddr1(ra1_2), .rf_raddr2(ra2_2), .rf_waddr(wa2), .rf_we(we2),
      .alu_op(aop2), .alu_src_imm(simm2), .imm_out(imm2),
      .pc(pc2), .busy(busy2), .halted(halted2), .fault(fault2), .instr_count(cnt2)
   );

   typedef struct {
      logic [7:0]  pc;
      logic [2:0]  wa, r1, r2;
      logic        we, aop, simm;
      logic [15:0] imm;
      int          lat;
   } exp_t;

   typedef struct {
      logic [7:0]  pc;
      logic [2:0]  wa, r1, r2;
      logic        we, aop, simm, busy;
      logic [15:0] imm, cnt;
   } snap_t;

   exp_t        expq[$];
   int          dq[$];
   logic [15:0] mem [256];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          seen_writes = 0;
   int          exp_writes  = 0;
   bit          no_ack = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Instruction memory responder: per-fetch delay taken from dq, junk data while waiting
   bit         in_fetch = 1'b0;
   int         wcnt = 0;
   int         cur_delay = 0;
   logic [7:0] first_addr = 8'd0;
   always @(negedge clk) begin
      if (reset || !imem_req) begin
         in_fetch   = 1'b0;
         imem_ack   = ($urandom_range(0, 3) == 0);
         imem_rdata = 16'($urandom);
      end else begin
         if (!in_fetch) begin
            in_fetch   = 1'b1;
            wcnt       = 0;
            cur_delay  = (dq.size() > 0) ? dq.pop_front() : 0;
            first_addr = imem_addr;
         end else begin
            chk("imem_addr_stable", 32'(imem_addr), 32'(first_addr));
         end
         if (!no_ack && wcnt == cur_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
            wcnt++;
         end
      end
   end

   // Monitor: a retirement shows up as instr_count stepping by one; the previous sample is the WB cycle
   snap_t prev;
   exp_t  me;
   bit    have_prev = 1'b0;
   int    cyc = 0;
   int    mark = 0;
   always @(negedge clk) begin
      if (reset) begin
         have_prev = 1'b0;
      end else begin
         if (rf_we) seen_writes++;
         if (have_prev && busy && !prev.busy) mark = cyc;
         if (have_prev && instr_count == prev.cnt + 16'd1) begin
            if (expq.size() == 0) begin
               chk("unexpected_retire", 32'(instr_count), 32'(prev.cnt));
            end else begin
               me = expq.pop_front();
               chk("wb_pc",       32'(prev.pc),   32'(me.pc));
               chk("wb_waddr",    32'(prev.wa),   32'(me.wa));
               chk("wb_raddr1",   32'(prev.r1),   32'(me.r1));
               chk("wb_raddr2",   32'(prev.r2),   32'(me.r2));
               chk("wb_rf_we",    32'(prev.we),   32'(me.we));
               chk("wb_alu_op",   32'(prev.aop),  32'(me.aop));
               chk("wb_src_imm",  32'(prev.simm), 32'(me.simm));
               chk("wb_imm_out",  32'(prev.imm),  32'(me.imm));
               chk("latency",     cyc - mark,     me.lat);
               mark = cyc;
            end
         end
         prev.pc   = pc;        prev.wa   = rf_waddr;  prev.r1  = rf_raddr1;
         prev.r2   = rf_raddr2; prev.we   = rf_we;     prev.aop = alu_op;
         prev.simm = alu_src_imm; prev.imm = imm_out;  prev.cnt = instr_count;
         prev.busy = busy;
         have_prev = 1'b1;
      end
      cyc++;
   end

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
   endtask

   // Instruction-level model: walk the program from address 0 until HALT, queue expectations, then run the DUT
   task automatic run_prog(input string tag, input int dly);
      int          p = 0;
      int          n = 0;
      int          op, v, d;
      logic [15:0] w;
      exp_t        e;
      while (1) begin
         w      = mem[p];
         op     = int'(w[15:13]);
         v      = int'(w[6:0]);
         if (v >= 64) v = v - 128;
         d      = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
         e.pc   = 8'(p);
         e.wa   = w[12:10];
         e.r1   = w[9:7];
         e.r2   = w[6:4];
         e.imm  = 16'(v);
         e.we   = (op <= 3);
         e.aop  = (op == 2 || op == 3);
         e.simm = (op == 1 || op == 2);
         e.lat  = 4 + d;
         dq.push_back(d);
         expq.push_back(e);
         if (e.we) exp_writes++;
         n++;
         if (op == 7 || n >= 200) break;
         p = (p + 1) % 256;
      end
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 0; c < 3000 && !halted; c++) begin
         @(negedge clk);
         start = busy && ($urandom_range(0, 7) == 0);
      end
      start = 1'b0;
      chk({tag, "_halted"}, 32'(halted), 1);
      repeat (2) @(negedge clk);
      chk({tag, "_pc"},     32'(pc), p);
      chk({tag, "_count"},  32'(instr_count), n);
      chk({tag, "_busy"},   32'(busy), 0);
      chk({tag, "_fault"},  32'(fault), 0);
      chk({tag, "_writes"}, seen_writes, exp_writes);
      chk({tag, "_queue"},  expq.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nf;
      bit saw;
      reset = 1'b1; start = 1'b0; start2 = 1'b0;
      imem_ack = 1'b0; imem_rdata = 16'd0;
      clear_mem();
      repeat (3) @(negedge clk);
      chk("rst_pc",      32'(pc), 0);
      chk("rst_count",   32'(instr_count), 0);
      chk("rst_busy",    32'(busy), 0);
      chk("rst_halted",  32'(halted), 0);
      chk("rst_fault",   32'(fault), 0);
      chk("rst_req",     32'(imem_req), 0);
      chk("rst_we",      32'(rf_we), 0);
      chk("rst_imm",     32'(imm_out), 0);
      reset = 1'b0;

      clear_mem(); mem[0] = 16'h2485;
      run_prog("addi", 0);
      clear_mem(); mem[0] = 16'h447F;
      run_prog("subi", 0);
      clear_mem(); mem[0] = 16'h0520; mem[1] = 16'h6520; mem[2] = 16'h8000; mem[3] = 16'hE000;
      run_prog("mix", 0);
      clear_mem(); mem[0] = 16'h2485; mem[1] = 16'h6520;
      run_prog("delay3", 3);

      // Fetch that is never acknowledged
      no_ack = 1'b1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      nf = 0;
      for (int c = 0; c < 100; c++) begin
         if (halted) break;
         if (imem_req) nf++;
         @(negedge clk);
      end
      no_ack = 1'b0;
      chk("to_fetch_cycles", nf, 16);
      chk("to_halted",       32'(halted), 1);
      chk("to_fault",        32'(fault), 1);
      chk("to_count",        32'(instr_count), 0);
      chk("to_busy",         32'(busy), 0);
      clear_mem(); mem[0] = 16'h2485; mem[1] = 16'hE000;
      run_prog("refetch", 0);

      for (int k = 0; k < 8; k++) begin
         int len;
         logic [15:0] w;
         clear_mem();
         len = int'($urandom_range(1, 12));
         for (int i = 0; i < len; i++) begin
            w = 16'($urandom);
            if (w[15:13] == 3'b111) w[15] = 1'b0;
            mem[i] = w;
         end
         mem[len] = 16'hE000 | 16'($urandom_range(0, 8191));
         run_prog("rand", -1);
      end

      // Reset asserted while a writing instruction is in WB
      clear_mem(); mem[0] = 16'h2485;
      dq.push_back(0);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      saw = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (rf_we) begin saw = 1'b1; break; end
         @(negedge clk);
      end
      chk("wbrst_reached_wb", 32'(saw), 1);
      if (saw) exp_writes++;
      #2 reset = 1'b1;
      #1;
      chk("wbrst_we",     32'(rf_we), 0);
      chk("wbrst_req",    32'(imem_req), 0);
      chk("wbrst_busy",   32'(busy), 0);
      chk("wbrst_pc",     32'(pc), 0);
      chk("wbrst_count",  32'(instr_count), 0);
      chk("wbrst_waddr",  32'(rf_waddr), 0);
      chk("wbrst_imm",    32'(imm_out), 0);
      @(negedge clk) reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("wbrst_idle_busy", 32'(busy), 0);
      chk("wbrst_writes",    seen_writes, exp_writes);

      // 2-bit pc wraps 3 -> 0
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         for (int c = 0; c < 40; c++) begin
            if (cnt2 == 16'(k)) break;
            @(negedge clk);
         end
         chk("wrap_count", 32'(cnt2), k);
         chk("wrap_pc",    32'(pc2), k % 4);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle fetch/decode/execute/writeback controller for the 16-bit register-file datapath. Fetches instructions from instruction memory over a req/ack handshake, holds them in an instruction register, and drives the datapath controls:
- register-file read/write addresses and write enable
- ALU operation select
- immediate select and sign-extended immediate

Also maintains the program counter, halt/fault status and a retired-instruction counter.

Parameters:
PC_W, 8, program counter / instruction address width
START_PC, 0, PC value loaded on reset and on start
FETCH_TIMEOUT, 16, maximum cycles FETCH waits for imem_ack before faulting (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; forces reset state immediately
start  in  1  begin or restart execution; honoured only in IDLE or HALT
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address, equals pc
imem_ack  in  1  fetch accepted; imem_rdata valid in the same cycle
imem_rdata  in  16  instruction word
rf_raddr1  out  3  source register 1 = IR[9:7]
rf_raddr2  out  3  source register 2 = IR[6:4]
rf_waddr  out  3  destination register = IR[12:10]
rf_we  out  1  register-file write enable, one-cycle pulse
alu_op  out  1  0 = add, 1 = subtract
alu_src_imm  out  1  1 = second ALU operand is imm_out
imm_out  out  16  IR[6:0] sign-extended (bit 6 replicated into [15:7])
pc  out  PC_W  current program counter
busy  out  1  high in FETCH, DECODE, EXEC, WB
halted  out  1  high in HALT
fault  out  1  sticky; set on fetch timeout
instr_count  out  16  retired instructions, saturates at 0xFFFF

Behaviour:
- Reset values: state IDLE; pc = START_PC; IR = 0; instr_count = 0; fault = 0; wait counter = 0. All control outputs are 0.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. State and IR are registered. All outputs are decoded from state, IR and pc (Moore).
- IDLE:
  - start=1 -> FETCH
  - pc <= START_PC, instr_count <= 0, fault <= 0
- FETCH:
  - imem_req = 1; imem_addr = pc, stable until ack.
  - On an edge with imem_ack=1: IR <= imem_rdata, wait counter cleared, -> DECODE.
  - Otherwise the wait counter increments. When it reaches FETCH_TIMEOUT-1 without ack: fault <= 1, -> HALT.
  - imem_ack outside FETCH is ignored.
- DECODE: rf_raddr1/2 valid (and remain valid through WB). -> EXEC.
- EXEC: alu_op, alu_src_imm and imm_out valid (and remain valid through WB). -> WB.
- WB, by opcode IR[15:13]:
  - 000 ADD: rf_we=1, alu_op=0, src_imm=0
  - 001 ADDI: rf_we=1, alu_op=0, src_imm=1
  - 010 SUBI: rf_we=1, alu_op=1, src_imm=1
  - 011 SUB: rf_we=1, alu_op=1, src_imm=0
  - 100..110: NOP, rf_we=0
  - 111: HALT, rf_we=0
- WB updates:
  - Non-HALT opcode: pc <= pc+1 (wraps modulo 2^PC_W), instr_count increments (saturating), -> FETCH.
  - HALT opcode: pc unchanged, instr_count increments, -> HALT.
- rf_we is high in WB only: exactly one cycle per writing instruction, never in any other state.
- Latency: 4 cycles per instruction when ack arrives in the first FETCH cycle, plus 1 cycle per ack wait cycle.
- HALT:
  - Outputs idle; halted=1; fault retained.
  - start=1 -> FETCH with the same side effects as from IDLE.
- start while busy is ignored.
- Reset asserted mid-instruction: immediate return to reset values. rf_we and imem_req fall asynchronously; no partial write occurs after reset assertion.

Test Plan:
- Reset, start, imem returns 0x2485 (ADDI r1,r1,5) with ack on the first FETCH cycle:
  - FETCH/DECODE/EXEC/WB take 4 cycles
  - rf_waddr=1, rf_raddr1=1, imm_out=0x0005, alu_op=0, src_imm=1
  - rf_we high exactly 1 cycle; pc 0->1; instr_count=1
- SUBI with imm7=0x7F (word 0x447F) -> imm_out=0xFFFF, alu_op=1, alu_src_imm=1.
- ADD (0x0520), SUB (0x6520), NOP (0x8000), HALT (0xE000) at pc 0..3:
  - rf_we pulses only for the first two
  - final pc=3, instr_count=4, halted=1, busy=0
- ack delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles; IR captures the data present at the ack edge.
- ack never given, FETCH_TIMEOUT=16 -> HALT after 16 FETCH cycles, fault=1; start then clears fault and refetches from START_PC.
- PC_W=2, four NOP instructions -> pc wraps 3->0. Reset asserted in WB -> rf_we drops immediately and all outputs return to reset values.
